ddsm_ctrl: RTL and testbench
============================

# ddsm_ctrl

Sequencing controller for the 3-stage MASH delta-sigma modulator on the Tx path. It accepts baseband samples from upstream through a valid/ready handshake and holds each one on the modulator input for a fixed number of clocks. It keeps the modulator cleared while idle and masks output during the noise-cancellation warm-up. On disable it drains the modulator to zero before clearing it, and it counts input underflows.

## Interface

**Parameters**
- `IN_WIDTH`, 13: sample width; matches the modulator input.
- `HOLD_CYCLES`, 8: clocks each accepted sample is held (≥2).
- `WARMUP_CYCLES`, 4: clocks of masked output after start; also the drain length (≥1).
- `UF_WIDTH`, 8: width of the underflow counter.

**Ports**
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run request (level).
- `clr_stats`  in  1  clears `underflow_cnt`.
- `in_valid`  in  1  upstream sample valid.
- `in_data`  in  IN_WIDTH  upstream sample.
- `in_ready`  out  1  controller accepts a sample this cycle.
- `ddsm_clr`  out  1  clear to the modulator (drives its `rst`).
- `ddsm_data`  out  IN_WIDTH  modulator input.
- `ddsm_out`  in  6  modulator output (DUC format).
- `out_valid`  out  1  `out_data` is valid.
- `out_data`  out  6  gated modulator output to the DUC.
- `underflow_cnt`  out  UF_WIDTH  saturating underflow count.
- `state_o`  out  3  current state (IDLE=0, LOAD=1, WARMUP=2, RUN=3, DRAIN=4).

## Operation

**Reset** (`rst`=1 at an edge): all of the following hold from the next cycle, regardless of the current state.
- State IDLE.
- `ddsm_clr`=1.
- `ddsm_data`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `underflow_cnt`=0.

**States**
- **IDLE**
  - `ddsm_clr`=1, `ddsm_data`=0.
  - `en`=1 → LOAD.
- **LOAD**
  - `in_ready`=1, `ddsm_clr`=1.
  - Accept (`in_valid`&`in_ready`) → WARMUP.
    - `ddsm_data`←`in_data`.
    - `hold_cnt`←HOLD_CYCLES−1, `warm_cnt`←WARMUP_CYCLES−1.
  - `en`=0 → IDLE.
- **WARMUP**
  - `ddsm_clr`=0, `out_valid`=0.
  - `warm_cnt` decrements; when it is 0 → RUN.
  - `en`=0 → DRAIN.
- **RUN**
  - Modulator active; output passes through.
  - `en`=0 → DRAIN.
- **DRAIN**
  - `ddsm_data`=0, `in_ready`=0, output still passes through.
  - Lasts WARMUP_CYCLES cycles, then → IDLE.
  - `en` is ignored until IDLE is reached.

**Hold/refill** (WARMUP and RUN only)
- `hold_cnt` decrements each cycle.
- `in_ready` = (`hold_cnt`==0) & `en`. It depends on registered state only, never on `in_valid`.
- At `hold_cnt`==0:
  - Accept → `ddsm_data`←`in_data` next cycle, `hold_cnt` reloads.
  - No accept while `en`=1 → underflow:
    - `ddsm_data` keeps its last value.
    - `hold_cnt` reloads.
    - `underflow_cnt` increments, saturating at all-ones.

**Statistics**
- `clr_stats` clears `underflow_cnt` next cycle.
- `clr_stats` together with an underflow in the same cycle: the clear wins.

**Output gating**
- `out_valid` ← (state ∈ {RUN, DRAIN}), registered.
- `out_data` ← that condition ? `ddsm_out` : 0, registered.

## Timing

- Accept at edge t: `ddsm_data` updates at t+1.
- Start-up, from the LOAD accept at t:
  - WARMUP covers cycles t+1..t+WARMUP_CYCLES.
  - RUN starts at t+WARMUP_CYCLES+1.
  - `out_valid`=1 from t+WARMUP_CYCLES+2.
- Steady state: exactly one `in_ready` pulse every HOLD_CYCLES cycles.
- `en` falls, sampled at edge t:
  - DRAIN starts at t+1.
  - IDLE starts at t+WARMUP_CYCLES+1.
  - `out_valid`=0 from t+WARMUP_CYCLES+2.
- `en`=0 together with `hold_cnt`==0: `in_ready`=0, no accept, no underflow.
- Reset mid-RUN: the next cycle matches the reset state; no partial drain.

## Structure

- Package `ddsm_ctrl_pkg`:
  - state enum and its 3-bit encoding;
  - DUC output width constant (6).
- Sub-module `ddsm_hold_timer`:
  - inputs: load and enable;
  - owns `hold_cnt`;
  - produces the `hold_done` and underflow strobe.
- The FSM, warm-up/drain counter and output register stay in `ddsm_ctrl`.

## Test plan

- **Reset:** reset, then `en`=1 and `in_valid` held high with `in_data`=0x0A5.
  - Accept at cycle t.
  - `ddsm_clr` falls at t+1.
  - `out_valid` rises at t+6 (defaults).
  - `in_ready` pulses every 8 cycles.
- **Underflow:** in RUN, drop `in_valid` for 3 hold windows.
  - `ddsm_data` holds its value.
  - `underflow_cnt`=3.
  - At count 255, further underflows leave it at 255.
- **Disable:** deassert `en` in RUN.
  - DRAIN for 4 cycles with `ddsm_data`=0.
  - IDLE with `ddsm_clr`=1.
  - `out_valid`=0 two cycles after DRAIN ends.
  - Reasserting `en` during DRAIN has no effect until IDLE.
- **Reset mid-operation:** assert `rst` in WARMUP.
  - Next cycle: `state_o`=0, all outputs at reset values.
- **Clear/underflow collision:** assert `clr_stats` in the same cycle as an underflow.
  - `underflow_cnt`=0.

Source files
------------

// File: rtl/ddsm_ctrl_pkg.sv
// Shared types and constants for the MASH delta-sigma modulator sequencer.
package ddsm_ctrl_pkg;

    // Width of the modulator output word handed to the DUC.
    localparam int DUC_W = 6;

    // Controller states; the encoding is visible on state_o.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WARMUP = 3'd2,
        ST_RUN    = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    // States in which the hold timer runs and samples are refilled.
    function automatic logic is_active(input state_t s);
        return (s == ST_WARMUP) || (s == ST_RUN);
    endfunction

    // States in which the modulator output is passed to the DUC.
    function automatic logic is_out_open(input state_t s);
        return (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/ddsm_hold_timer.sv
// Sample hold timer: counts the clocks a sample sits on the modulator input
// and flags the refill slot plus a missed refill (underflow).
import ddsm_ctrl_pkg::*;

module ddsm_hold_timer #(
    parameter int HOLD_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,      // first sample accepted, start a hold window
    input  logic i_enable,    // controller is in a refilling state
    input  logic i_run_req,   // upstream run request (en)
    input  logic i_valid,     // upstream sample valid
    output logic o_hold_done, // refill slot: hold window has expired
    output logic o_underflow  // refill slot missed while running
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] r_hold_cnt;

    // Count down each active cycle; the window reloads whether or not the
    // slot was filled, so a missed sample costs exactly one window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= HOLD_RELOAD;
        end else if (i_load) begin
            r_hold_cnt <= HOLD_RELOAD;
        end else if (i_enable) begin
            if (r_hold_cnt == '0) begin
                r_hold_cnt <= HOLD_RELOAD;
            end else begin
                r_hold_cnt <= r_hold_cnt - CW'(1);
            end
        end
    end

    assign o_hold_done = i_enable && (r_hold_cnt == '0);
    // A slot with en low is not a miss: the controller is about to drain.
    assign o_underflow = o_hold_done && i_run_req && !i_valid;

endmodule

// File: rtl/ddsm_ctrl.sv
// Sequencing controller for the 3-stage MASH delta-sigma modulator.
// Handshake: a sample transfers on any rising edge where in_valid and
// in_ready are both high; in_ready is derived from registered state and en
// only, never from in_valid, and in_data must be stable while in_valid is high.
import ddsm_ctrl_pkg::*;

module ddsm_ctrl #(
    parameter int IN_WIDTH      = 13,
    parameter int HOLD_CYCLES   = 8,
    parameter int WARMUP_CYCLES = 4,
    parameter int UF_WIDTH      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr_stats,
    input  logic                in_valid,
    input  logic [IN_WIDTH-1:0] in_data,
    output logic                in_ready,
    output logic                ddsm_clr,
    output logic [IN_WIDTH-1:0] ddsm_data,
    input  logic [DUC_W-1:0]    ddsm_out,
    output logic                out_valid,
    output logic [DUC_W-1:0]    out_data,
    output logic [UF_WIDTH-1:0] underflow_cnt,
    output logic [2:0]          state_o
);

    localparam int WCW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [WCW-1:0] WARM_RELOAD = WCW'(WARMUP_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [WCW-1:0]      r_warm_cnt;
    logic [IN_WIDTH-1:0] r_ddsm_data;
    logic                r_out_valid;
    logic [DUC_W-1:0]    r_out_data;
    logic [UF_WIDTH-1:0] r_uf_cnt;

    logic w_in_ready;
    logic w_ddsm_clr;
    logic w_accept;
    logic w_hold_done;
    logic w_underflow;
    logic w_first_load;
    logic w_warm_zero;

    assign w_accept     = in_valid && w_in_ready;
    assign w_first_load = (r_state == ST_LOAD) && w_accept;
    assign w_warm_zero  = (r_warm_cnt == '0);

    ddsm_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_first_load),
        .i_enable    (is_active(r_state)),
        .i_run_req   (en),
        .i_valid     (in_valid),
        .o_hold_done (w_hold_done),
        .o_underflow (w_underflow)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; DRAIN ignores en so the modulator always settles.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (en) w_state_next = ST_LOAD;
            ST_LOAD: begin
                if (w_accept)  w_state_next = ST_WARMUP;
                else if (!en)  w_state_next = ST_IDLE;
            end
            ST_WARMUP: begin
                if (!en)              w_state_next = ST_DRAIN;
                else if (w_warm_zero) w_state_next = ST_RUN;
            end
            ST_RUN:    if (!en) w_state_next = ST_DRAIN;
            ST_DRAIN:  if (w_warm_zero) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs: modulator clear and upstream ready.
    always_comb begin
        w_ddsm_clr = 1'b0;
        w_in_ready = 1'b0;
        case (r_state)
            ST_IDLE:   w_ddsm_clr = 1'b1;
            ST_LOAD: begin
                w_ddsm_clr = 1'b1;
                w_in_ready = 1'b1;
            end
            ST_WARMUP: w_in_ready = w_hold_done && en;
            ST_RUN:    w_in_ready = w_hold_done && en;
            default: begin
                w_ddsm_clr = 1'b0;
                w_in_ready = 1'b0;
            end
        endcase
    end

    // Shared warm-up / drain counter: both phases last WARMUP_CYCLES clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_warm_cnt <= '0;
        end else if (w_first_load) begin
            r_warm_cnt <= WARM_RELOAD;
        end else if (is_active(r_state) && !en) begin
            r_warm_cnt <= WARM_RELOAD;
        end else if (((r_state == ST_WARMUP) || (r_state == ST_DRAIN)) && !w_warm_zero) begin
            r_warm_cnt <= r_warm_cnt - WCW'(1);
        end
    end

    // Modulator input: capture on accept, hold on underflow, zero outside
    // WARMUP/RUN so the modulator drains toward zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ddsm_data <= '0;
        end else if (w_accept) begin
            r_ddsm_data <= in_data;
        end else if (!is_active(w_state_next)) begin
            r_ddsm_data <= '0;
        end
    end

    // Output gate, registered: masks warm-up garbage, passes RUN and DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= is_out_open(r_state);
            r_out_data  <= is_out_open(r_state) ? ddsm_out : '0;
        end
    end

    // Saturating underflow counter; a clear in the same cycle wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_uf_cnt <= '0;
        end else if (clr_stats) begin
            r_uf_cnt <= '0;
        end else if (w_underflow && !(&r_uf_cnt)) begin
            r_uf_cnt <= r_uf_cnt + UF_WIDTH'(1);
        end
    end

    assign in_ready      = w_in_ready;
    assign ddsm_clr      = w_ddsm_clr;
    assign ddsm_data     = r_ddsm_data;
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign underflow_cnt = r_uf_cnt;
    assign state_o       = r_state;

endmodule

// File: tb/tb_ddsm_ctrl.sv
// Directed bench for ddsm_ctrl with default parameters.
module tb_ddsm_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        clr_stats;
    logic        in_valid;
    logic [12:0] in_data;
    logic        in_ready;
    logic        ddsm_clr;
    logic [12:0] ddsm_data;
    logic [5:0]  ddsm_out;
    logic        out_valid;
    logic [5:0]  out_data;
    logic [7:0]  underflow_cnt;
    logic [2:0]  state_o;

    int checks   = 0;
    int failures = 0;

    ddsm_ctrl #(
        .IN_WIDTH      (13),
        .HOLD_CYCLES   (8),
        .WARMUP_CYCLES (4),
        .UF_WIDTH      (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .clr_stats     (clr_stats),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .ddsm_clr      (ddsm_clr),
        .ddsm_data     (ddsm_data),
        .ddsm_out      (ddsm_out),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .underflow_cnt (underflow_cnt),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_state"},     32'(state_o),       32'd0);
        chk({tag, "_clr"},       32'(ddsm_clr),      32'd1);
        chk({tag, "_data"},      32'(ddsm_data),     32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),      32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid),     32'd0);
        chk({tag, "_out_data"},  32'(out_data),      32'd0);
        chk({tag, "_uf"},        32'(underflow_cnt), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        clr_stats = 1'b0;
        in_valid  = 1'b0;
        in_data   = 13'h0;
        ddsm_out  = 6'h2A;
        step(2);
        chk_reset_state("reset");

        // Start-up: LOAD, accept at edge t, WARMUP t+1..t+4, RUN at t+5.
        rst      = 1'b0;
        en       = 1'b1;
        in_valid = 1'b1;
        in_data  = 13'h0A5;
        step(1);
        chk("load_state",    32'(state_o),  32'd1);
        chk("load_in_ready", 32'(in_ready), 32'd1);
        chk("load_clr",      32'(ddsm_clr), 32'd1);
        step(1); // t+1
        chk("warm_state",     32'(state_o),   32'd2);
        chk("warm_clr",       32'(ddsm_clr),  32'd0);
        chk("warm_data",      32'(ddsm_data), 32'h0A5);
        chk("warm_in_ready",  32'(in_ready),  32'd0);
        chk("warm_out_valid", 32'(out_valid), 32'd0);
        step(3); // t+4
        chk("warm_last_state", 32'(state_o), 32'd2);
        step(1); // t+5
        chk("run_state",       32'(state_o),   32'd3);
        chk("run_out_valid_0", 32'(out_valid), 32'd0);
        step(1); // t+6
        chk("run_out_valid_1", 32'(out_valid), 32'd1);
        chk("run_out_data",    32'(out_data),  32'h2A);
        step(1); // t+7
        chk("pre_slot_ready", 32'(in_ready), 32'd0);
        in_data  = 13'h123;
        ddsm_out = 6'h15;
        step(1); // t+8
        chk("slot1_ready",     32'(in_ready),  32'd1);
        chk("slot1_data_old",  32'(ddsm_data), 32'h0A5);
        chk("out_data_follow", 32'(out_data),  32'h15);
        step(1); // t+9
        chk("slot1_data_new", 32'(ddsm_data), 32'h123);
        chk("post_slot_ready", 32'(in_ready), 32'd0);
        step(7); // t+16
        chk("slot2_ready", 32'(in_ready), 32'd1);

        // Underflow: three missed windows, data held.
        in_valid = 1'b0;
        step(1); // t+17
        chk("uf_1",      32'(underflow_cnt), 32'd1);
        chk("uf_1_data", 32'(ddsm_data),     32'h123);
        step(15); // t+32
        chk("slot4_ready", 32'(in_ready),      32'd1);
        chk("uf_2",        32'(underflow_cnt), 32'd2);
        step(1); // t+33
        chk("uf_3",      32'(underflow_cnt), 32'd3);
        chk("uf_3_data", 32'(ddsm_data),     32'h123);

        // Clear collides with an underflow: clear wins.
        step(7); // t+40
        chk("slot5_ready", 32'(in_ready), 32'd1);
        clr_stats = 1'b1;
        step(1); // t+41
        chk("clr_collide", 32'(underflow_cnt), 32'd0);
        clr_stats = 1'b0;

        // Disable exactly on a refill slot: no ready, no underflow.
        step(7); // t+48
        chk("slot6_ready_en", 32'(in_ready), 32'd1);
        en = 1'b0;
        #1;
        chk("slot6_ready_dis", 32'(in_ready), 32'd0);
        step(1); // t+49, first DRAIN cycle
        chk("drain_state",     32'(state_o),       32'd4);
        chk("drain_data",      32'(ddsm_data),     32'd0);
        chk("drain_no_uf",     32'(underflow_cnt), 32'd0);
        chk("drain_clr",       32'(ddsm_clr),      32'd0);
        chk("drain_out_valid", 32'(out_valid),     32'd1);
        chk("drain_in_ready",  32'(in_ready),      32'd0);
        en = 1'b1; // must be ignored until IDLE
        step(3); // t+52, last DRAIN cycle
        chk("drain_last_state", 32'(state_o),   32'd4);
        chk("drain_last_data",  32'(ddsm_data), 32'd0);
        step(1); // t+53
        chk("idle_state",     32'(state_o),   32'd0);
        chk("idle_clr",       32'(ddsm_clr),  32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd1);
        step(1); // t+54
        chk("idle_out_valid_0", 32'(out_valid), 32'd0);
        chk("idle_out_data_0",  32'(out_data),  32'd0);
        chk("reload_state",     32'(state_o),   32'd1);

        // Saturation: restart and starve upstream for 256 windows.
        in_valid = 1'b1;
        in_data  = 13'h055;
        step(1); // t2+1
        chk("sat_warm_state", 32'(state_o),   32'd2);
        chk("sat_warm_data",  32'(ddsm_data), 32'h055);
        in_valid = 1'b0;
        step(2040);
        chk("sat_255",      32'(underflow_cnt), 32'd255);
        chk("sat_255_data", 32'(ddsm_data),     32'h055);
        step(8);
        chk("sat_hold_255", 32'(underflow_cnt), 32'd255);

        // Drain to IDLE, restart, then reset in the middle of WARMUP.
        en = 1'b0;
        step(5);
        chk("sat_idle_state", 32'(state_o), 32'd0);
        en       = 1'b1;
        in_valid = 1'b1;
        in_data  = 13'h1FF;
        step(1);
        chk("rst_load_state", 32'(state_o), 32'd1);
        step(1);
        chk("rst_warm_state", 32'(state_o),       32'd2);
        chk("rst_warm_data",  32'(ddsm_data),     32'h1FF);
        chk("rst_warm_uf",    32'(underflow_cnt), 32'd255);
        rst = 1'b1;
        step(1);
        chk_reset_state("mid_rst");
        rst = 1'b0;
        en  = 1'b0;
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
